// File: rtl/dnn_mlp_fix_if.sv
// Host/memory bundle of the two-layer fixed-point MLP engine.
// The class_idx member exists only when DNN_ARGMAX_EN is defined.
interface dnn_mlp_fix_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 16,
    parameter int N_OUT      = 10
);
    logic                         start;
    logic                         reset;
    logic signed [DATA_WIDTH-1:0] mem_data;
    logic        [ADDR_WIDTH-1:0] mem_addr;
    logic                         done;
    logic signed [DATA_WIDTH-1:0] out [N_OUT];
`ifdef DNN_ARGMAX_EN
    logic [$clog2(N_OUT)-1:0]     class_idx;
`endif

    modport master (
        input  start, reset, mem_data,
        output mem_addr, done, out
`ifdef DNN_ARGMAX_EN
        , output class_idx
`endif
    );

    modport slave (
        output start, reset, mem_data,
        input  mem_addr, done, out
`ifdef DNN_ARGMAX_EN
        , input class_idx
`endif
    );
endinterface

// File: rtl/dnn_mlp_fix_engine.sv
// Two-layer fixed-point MLP inference engine: one memory read per cycle, sequential MAC,
// ReLU+saturation on hidden neurons, saturated logits. Optional argmax via DNN_ARGMAX_EN.
module dnn_mlp_fix_engine #(
    parameter int DATA_WIDTH = 12,
    parameter int FRAC_BITS  = 10,
    parameter int ADDR_WIDTH = 16,
    parameter int N_IN       = 400,
    parameter int N_HID      = 25,
    parameter int N_OUT      = 10,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = ADDR_WIDTH'('h0000),
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = ADDR_WIDTH'('h0191)
) (
    input logic        clk,
    input logic        rst,
    dnn_mlp_fix_if.master bus
);
    localparam int ACC_W  = 2*DATA_WIDTH + $clog2(N_IN+2);
    localparam int OPND_W = DATA_WIDTH + 1;
    localparam int PROD_W = 2*DATA_WIDTH + 1;
    localparam int CNT_W  = $clog2(2*N_IN + N_HID + 8);
    localparam int HID_IW = $clog2(N_HID);
    localparam int OUT_IW = $clog2(N_OUT);

    localparam logic [CNT_W-1:0]  L1_BIAS_CNT = CNT_W'(2*N_IN);
    localparam logic [CNT_W-1:0]  L1_PRE_BIAS = CNT_W'(2*N_IN - 1);
    localparam logic [CNT_W-1:0]  L1_LAST_CNT = CNT_W'(2*N_IN + 2);
    localparam logic [CNT_W-1:0]  L2_BIAS_CNT = CNT_W'(N_HID);
    localparam logic [CNT_W-1:0]  L2_LAST_CNT = CNT_W'(N_HID + 2);
    localparam logic [HID_IW-1:0] HID_LAST    = HID_IW'(N_HID - 1);
    localparam logic [OUT_IW-1:0] OUT_LAST    = OUT_IW'(N_OUT - 1);

    localparam logic signed [OPND_W-1:0] ONE_OPND = OPND_W'(1 << FRAC_BITS);
    localparam logic signed [ACC_W-1:0]  SAT_HI   =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_LO   = ~SAT_HI;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_RUN, S_L1_STORE, S_L2_RUN, S_L2_STORE, S_FINISH, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_ACT, K_WT, K_HWT, K_BIAS} kind_t;

    function automatic logic signed [DATA_WIDTH-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_BITS;
        if (s > SAT_HI)      sat_fn = SAT_HI[DATA_WIDTH-1:0];
        else if (s < SAT_LO) sat_fn = SAT_LO[DATA_WIDTH-1:0];
        else                 sat_fn = s[DATA_WIDTH-1:0];
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] relu_sat_fn(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1]) relu_sat_fn = '0;
        else            relu_sat_fn = sat_fn(a);
    endfunction

    logic                          clr;
    state_t                        state;
    logic [CNT_W-1:0]              cnt;
    logic [HID_IW-1:0]             j;
    logic [OUT_IW-1:0]             k;
    logic [ADDR_WIDTH-1:0]         mem_addr_r, act_ptr, wt_ptr;
    logic                          done_r;
    logic                          vld_p0, vld_p1;
    kind_t                         kind_p0, kind_p1;
    logic [HID_IW-1:0]             idx_p0, idx_p1;
    logic signed [DATA_WIDTH-1:0]  data_p1;
    logic signed [OPND_W-1:0]      opnd_p1;
    logic signed [PROD_W-1:0]      prod_p1;
    logic signed [DATA_WIDTH-1:0]  act_p2;
    logic signed [ACC_W-1:0]       acc_p2;
    logic signed [DATA_WIDTH-1:0]  hidden [N_HID];
    logic signed [DATA_WIDTH-1:0]  logit  [N_OUT];

    assign clr = rst | bus.reset;

`ifdef DNN_ARGMAX_EN
    logic [OUT_IW-1:0]            class_r, best_idx;
    logic signed [DATA_WIDTH-1:0] best_val;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = logit[0];
        for (int n = 1; n < N_OUT; n++) begin
            if (logit[n] > best_val) begin
                best_val = logit[n];
                best_idx = OUT_IW'(n);
            end
        end
    end

    assign bus.class_idx = class_r;
`endif

    // Stage p0: sequencing, address issue and tagging of each issued read.
    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= S_IDLE;
            cnt        <= '0;
            j          <= '0;
            k          <= '0;
            mem_addr_r <= '0;
            act_ptr    <= '0;
            wt_ptr     <= '0;
            done_r     <= 1'b0;
            vld_p0     <= 1'b0;
            kind_p0    <= K_ACT;
            idx_p0     <= '0;
`ifdef DNN_ARGMAX_EN
            class_r    <= '0;
`endif
        end else begin
            vld_p0 <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state      <= S_L1_RUN;
                        cnt        <= '0;
                        j          <= '0;
                        k          <= '0;
                        mem_addr_r <= ADDR_BASE_A;
                        act_ptr    <= ADDR_BASE_A + ADDR_WIDTH'(1);
                        wt_ptr     <= ADDR_BASE_W;
                        done_r     <= 1'b0;
                    end
                end
                S_L1_RUN: begin
                    if (cnt <= L1_BIAS_CNT) begin
                        vld_p0  <= 1'b1;
                        kind_p0 <= (cnt == L1_BIAS_CNT) ? K_BIAS : (cnt[0] ? K_WT : K_ACT);
                    end
                    // Next slot is a weight when its index is odd or it is the bias slot.
                    if (cnt < L1_BIAS_CNT) begin
                        if (!cnt[0] || cnt == L1_PRE_BIAS) begin
                            mem_addr_r <= wt_ptr;
                            wt_ptr     <= wt_ptr + ADDR_WIDTH'(1);
                        end else begin
                            mem_addr_r <= act_ptr;
                            act_ptr    <= act_ptr + ADDR_WIDTH'(1);
                        end
                    end
                    if (cnt == L1_LAST_CNT) state <= S_L1_STORE;
                    else                    cnt   <= cnt + CNT_W'(1);
                end
                S_L1_STORE: begin
                    cnt <= '0;
                    if (j == HID_LAST) begin
                        state      <= S_L2_RUN;
                        mem_addr_r <= wt_ptr;
                        wt_ptr     <= wt_ptr + ADDR_WIDTH'(1);
                    end else begin
                        state      <= S_L1_RUN;
                        j          <= j + HID_IW'(1);
                        mem_addr_r <= ADDR_BASE_A;
                        act_ptr    <= ADDR_BASE_A + ADDR_WIDTH'(1);
                    end
                end
                S_L2_RUN: begin
                    if (cnt <= L2_BIAS_CNT) begin
                        vld_p0  <= 1'b1;
                        kind_p0 <= (cnt == L2_BIAS_CNT) ? K_BIAS : K_HWT;
                        idx_p0  <= cnt[HID_IW-1:0];
                    end
                    if (cnt < L2_BIAS_CNT) begin
                        mem_addr_r <= wt_ptr;
                        wt_ptr     <= wt_ptr + ADDR_WIDTH'(1);
                    end
                    if (cnt == L2_LAST_CNT) state <= S_L2_STORE;
                    else                    cnt   <= cnt + CNT_W'(1);
                end
                S_L2_STORE: begin
                    cnt <= '0;
                    if (k == OUT_LAST) begin
                        state <= S_FINISH;
                    end else begin
                        state      <= S_L2_RUN;
                        k          <= k + OUT_IW'(1);
                        mem_addr_r <= wt_ptr;
                        wt_ptr     <= wt_ptr + ADDR_WIDTH'(1);
                    end
                end
                S_FINISH: begin
                    state  <= S_DONE;
                    done_r <= 1'b1;
`ifdef DNN_ARGMAX_EN
                    class_r <= best_idx;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage p1: memory data capture; stage p2: activation latch and MAC.
    always_ff @(posedge clk) begin
        data_p1 <= bus.mem_data;
        if (vld_p1 && kind_p1 == K_ACT) act_p2 <= data_p1;
    end

    always_comb begin
        case (kind_p1)
            K_WT:    opnd_p1 = OPND_W'(act_p2);
            K_HWT:   opnd_p1 = OPND_W'(hidden[idx_p1]);
            default: opnd_p1 = ONE_OPND;
        endcase
    end

    assign prod_p1 = PROD_W'(opnd_p1) * PROD_W'(data_p1);

    always_ff @(posedge clk) begin
        if (clr) begin
            vld_p1  <= 1'b0;
            kind_p1 <= K_ACT;
            idx_p1  <= '0;
            acc_p2  <= '0;
            hidden  <= '{default: '0};
            logit   <= '{default: '0};
        end else begin
            vld_p1  <= vld_p0;
            kind_p1 <= kind_p0;
            idx_p1  <= idx_p0;
            if (state == S_L1_STORE) begin
                hidden[j] <= relu_sat_fn(acc_p2);
                acc_p2    <= '0;
            end else if (state == S_L2_STORE) begin
                logit[k] <= sat_fn(acc_p2);
                acc_p2   <= '0;
            end else if (vld_p1 && kind_p1 != K_ACT) begin
                acc_p2 <= acc_p2 + ACC_W'(prod_p1);
            end
        end
    end

    assign bus.mem_addr = mem_addr_r;
    assign bus.done     = done_r;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        assign bus.out[g] = logit[g];
    end
endmodule

// File: tb/tb_dnn_mlp_fix_engine.sv
// Directed bench for dnn_mlp_fix_engine in the small N_IN=2/N_HID=2/N_OUT=2 configuration.
module tb_dnn_mlp_fix_engine;
    localparam int DW = 12;
    localparam int T_LAT = 29;

    logic clk = 1'b0;
    logic rst;
    int   ncmp = 0;
    int   nfail = 0;
    logic signed [DW-1:0] mem [16];

    dnn_mlp_fix_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(16), .N_OUT(2)) bus ();

    dnn_mlp_fix_engine #(
        .DATA_WIDTH(DW), .FRAC_BITS(10), .ADDR_WIDTH(16),
        .N_IN(2), .N_HID(2), .N_OUT(2),
        .ADDR_BASE_A(16'h0000), .ADDR_BASE_W(16'h0002)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous read memory: data one cycle after the address.
    always @(posedge clk)
        bus.mem_data <= (bus.mem_addr < 16) ? mem[bus.mem_addr[3:0]] : '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v [14]);
        for (int i = 0; i < 16; i++) mem[i] = (i < 14) ? DW'(v[i]) : '0;
    endtask

    task automatic run(output int lat, output logic done0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        done0 = bus.done;
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            tick;
            if (bus.done === 1'b1) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        rst = 1'b0;
        tick;
        tick;
        ncmp++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        ncmp++; if (bus.mem_addr !== 16'd0) begin nfail++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
        for (int k = 0; k < 2; k++) begin
            ncmp++; if (bus.out[k] !== 12'sd0) begin nfail++; $display("FAIL reset_out%0d: got %0d expected 0", k, bus.out[k]); end
        end
`ifdef DNN_ARGMAX_EN
        ncmp++; if (bus.class_idx !== 1'b0) begin nfail++; $display("FAIL reset_class: got %0d expected 0", bus.class_idx); end
`endif
    endtask

    task automatic test_nominal;
        int v [14];
        int exp_o [2];
        int lat;
        logic d0;
        v = '{512, 512, 1024, 1024, 0, -1024, -1024, 0, 512, 0, 256, 0, 0, -300};
        exp_o = '{768, -300};
        load(v);
        run(lat, d0);
        ncmp++; if (lat != T_LAT) begin nfail++; $display("FAIL nominal_latency: got %0d expected %0d", lat, T_LAT); end
        for (int k = 0; k < 2; k++) begin
            ncmp++; if (bus.out[k] !== DW'(exp_o[k])) begin nfail++; $display("FAIL nominal_out%0d: got %0d expected %0d", k, bus.out[k], exp_o[k]); end
        end
`ifdef DNN_ARGMAX_EN
        ncmp++; if (bus.class_idx !== 1'b0) begin nfail++; $display("FAIL nominal_class: got %0d expected 0", bus.class_idx); end
`endif
    endtask

    task automatic test_hold;
        repeat (4) tick;
        ncmp++; if (bus.done !== 1'b1) begin nfail++; $display("FAIL hold_done: got %0b expected 1", bus.done); end
        ncmp++; if (bus.out[0] !== 12'sd768) begin nfail++; $display("FAIL hold_out0: got %0d expected 768", bus.out[0]); end
        ncmp++; if (bus.out[1] !== -12'sd300) begin nfail++; $display("FAIL hold_out1: got %0d expected -300", bus.out[1]); end
        ncmp++; if (bus.mem_addr !== 16'd13) begin nfail++; $display("FAIL hold_addr: got %0d expected 13", bus.mem_addr); end
    endtask

    task automatic test_addr_trace;
        int exp_tr [30];
        logic [15:0] tr [30];
        exp_tr = '{0, 2, 1, 3, 4, 4, 4, 4, 0, 5, 1, 6, 7, 7, 7, 7,
                   8, 9, 10, 10, 10, 10, 11, 12, 13, 13, 13, 13, 13, 13};
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tr[0] = bus.mem_addr;
        for (int e = 1; e < 30; e++) begin
            tick;
            tr[e] = bus.mem_addr;
        end
        for (int e = 0; e < 30; e++) begin
            ncmp++; if (tr[e] !== 16'(exp_tr[e])) begin nfail++; $display("FAIL addr_trace_e%0d: got %0d expected %0d", e, tr[e], exp_tr[e]); end
        end
        ncmp++; if (bus.done !== 1'b1) begin nfail++; $display("FAIL addr_trace_done: got %0b expected 1", bus.done); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic d0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        repeat (9) tick;
        bus.reset = 1'b1;
        tick;
        bus.reset = 1'b0;
        ncmp++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL midreset_done: got %0b expected 0", bus.done); end
        ncmp++; if (bus.mem_addr !== 16'd0) begin nfail++; $display("FAIL midreset_addr: got %0d expected 0", bus.mem_addr); end
        for (int k = 0; k < 2; k++) begin
            ncmp++; if (bus.out[k] !== 12'sd0) begin nfail++; $display("FAIL midreset_out%0d: got %0d expected 0", k, bus.out[k]); end
        end
        repeat (5) tick;
        ncmp++; if (bus.done !== 1'b0 || bus.mem_addr !== 16'd0) begin nfail++; $display("FAIL midreset_idle: got done=%0b addr=%0d expected done=0 addr=0", bus.done, bus.mem_addr); end
        run(lat, d0);
        ncmp++; if (lat != T_LAT) begin nfail++; $display("FAIL midreset_latency: got %0d expected %0d", lat, T_LAT); end
        ncmp++; if (bus.out[0] !== 12'sd768) begin nfail++; $display("FAIL midreset_out0: got %0d expected 768", bus.out[0]); end
        ncmp++; if (bus.out[1] !== -12'sd300) begin nfail++; $display("FAIL midreset_out1: got %0d expected -300", bus.out[1]); end
    endtask

    task automatic test_neg_relu;
        int v [14];
        int lat;
        logic d0;
        v = '{2047, 2047, 2047, 2047, 2047, -2048, -2048, -2048,
              0, 1024, 0, -2048, -2048, -2048};
        load(v);
        run(lat, d0);
        ncmp++; if (lat != T_LAT) begin nfail++; $display("FAIL neg_latency: got %0d expected %0d", lat, T_LAT); end
        ncmp++; if (bus.out[0] !== 12'sd0) begin nfail++; $display("FAIL neg_relu_out0: got %0d expected 0", bus.out[0]); end
        ncmp++; if (bus.out[1] !== -12'sd2048) begin nfail++; $display("FAIL neg_sat_out1: got %0d expected -2048", bus.out[1]); end
`ifdef DNN_ARGMAX_EN
        ncmp++; if (bus.class_idx !== 1'b0) begin nfail++; $display("FAIL neg_class: got %0d expected 0", bus.class_idx); end
`endif
    endtask

    task automatic test_pos_sat;
        int v [14];
        int lat;
        logic d0;
        for (int i = 0; i < 14; i++) v[i] = 2047;
        load(v);
        run(lat, d0);
        ncmp++; if (d0 !== 1'b0) begin nfail++; $display("FAIL possat_done_drop: got %0b expected 0", d0); end
        ncmp++; if (lat != T_LAT) begin nfail++; $display("FAIL possat_latency: got %0d expected %0d", lat, T_LAT); end
        for (int k = 0; k < 2; k++) begin
            ncmp++; if (bus.out[k] !== 12'sd2047) begin nfail++; $display("FAIL possat_out%0d: got %0d expected 2047", k, bus.out[k]); end
        end
`ifdef DNN_ARGMAX_EN
        ncmp++; if (bus.class_idx !== 1'b0) begin nfail++; $display("FAIL possat_tie_class: got %0d expected 0", bus.class_idx); end
`endif
    endtask

    task automatic test_back_to_back;
        int v [14];
        int lat;
        v = '{512, 512, 1024, 1024, 0, -1024, -1024, 0, 512, 0, 256, 0, 0, -300};
        load(v);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        ncmp++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL b2b_done_drop: got %0b expected 0", bus.done); end
        repeat (21) tick;
        ncmp++; if (bus.out[0] !== 12'sd2047) begin nfail++; $display("FAIL b2b_out0_before: got %0d expected 2047", bus.out[0]); end
        tick;
        ncmp++; if (bus.out[0] !== 12'sd768) begin nfail++; $display("FAIL b2b_out0_after: got %0d expected 768", bus.out[0]); end
        ncmp++; if (bus.out[1] !== 12'sd2047) begin nfail++; $display("FAIL b2b_out1_stable: got %0d expected 2047", bus.out[1]); end
        ncmp++; if (bus.done !== 1'b0) begin nfail++; $display("FAIL b2b_done_mid: got %0b expected 0", bus.done); end
        lat = -1;
        for (int e = 23; e <= 200; e++) begin
            tick;
            if (bus.done === 1'b1) begin
                lat = e;
                break;
            end
        end
        ncmp++; if (lat != T_LAT) begin nfail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, T_LAT); end
        ncmp++; if (bus.out[1] !== -12'sd300) begin nfail++; $display("FAIL b2b_out1: got %0d expected -300", bus.out[1]); end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.reset = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset;
        test_nominal;
        test_hold;
        test_addr_trace;
        test_reset_mid;
        test_neg_relu;
        test_pos_sat;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
